// File: rtl/medidor_tono_if.sv
// medidor_tono_if: tone input and period/key measurement results of the tone meter
interface medidor_tono_if #(
    parameter int PER_W = 22
);
    logic             tono_in;
    logic [PER_W-1:0] periodo;
    logic             periodo_valid;
    logic [6:0]       tecla;
    logic             silencio;

    modport master (output tono_in, input periodo, periodo_valid, tecla, silencio);
    modport slave  (input tono_in, output periodo, periodo_valid, tecla, silencio);
endinterface

// File: rtl/medidor_tono.sv
// medidor_tono: measures the tone square-wave period in clk cycles and decodes it to a one-hot key
module medidor_tono #(
    parameter int PER_W   = 22,
    parameter int TIMEOUT = 2000000,
    parameter int TOL     = 1024,
    parameter int P_DO    = 191113,
    parameter int P_RE    = 170265,
    parameter int P_MI    = 151685,
    parameter int P_FA    = 143172,
    parameter int P_SOL   = 127551,
    parameter int P_LA    = 113636,
    parameter int P_SI    = 101239
) (
    input  logic                 clk,
    input  logic                 reset,
    medidor_tono_if.slave        m_if
);
    typedef enum logic {ESPERA, MIDIENDO} state_t;

    localparam logic [PER_W-1:0] TMO   = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] TOL_V = PER_W'(TOL);
    localparam logic [PER_W-1:0] NOM [7] = '{PER_W'(P_DO), PER_W'(P_RE), PER_W'(P_MI), PER_W'(P_FA),
                                             PER_W'(P_SOL), PER_W'(P_LA), PER_W'(P_SI)};

    logic             r_sync1, r_sync2, r_prev, r_sube;
    state_t           r_state, w_state_n;
    logic [PER_W-1:0] r_cnt, w_cnt_n;
    logic [PER_W-1:0] r_periodo;
    logic             r_valid;
    logic [6:0]       r_tecla, w_dec;
    logic             r_sil;
    logic             w_meas, w_tout;

    // Scanning from the highest index down lets the lowest matching key win.
    function automatic logic [6:0] decode(input logic [PER_W-1:0] c);
        logic [PER_W-1:0] d;
        decode = '0;
        for (int i = 6; i >= 0; i--) begin
            d = (c >= NOM[i]) ? c - NOM[i] : NOM[i] - c;
            if (d <= TOL_V) begin
                decode    = '0;
                decode[i] = 1'b1;
            end
        end
    endfunction

    // Two-flop synchronizer on the asynchronous tone, then a registered rising-edge strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_sube  <= 1'b0;
        end else begin
            r_sync1 <= m_if.tono_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_sube  <= r_sync2 & ~r_prev;
        end
    end

    // Next state and counter: the first edge only arms, later edges end a period, a full count means silence.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = '0;
        w_meas    = 1'b0;
        w_tout    = 1'b0;
        w_dec     = decode(r_cnt);
        if (r_state == ESPERA) begin
            if (r_sube) begin
                w_state_n = MIDIENDO;
                w_cnt_n   = PER_W'(1);
            end
        end else if (r_sube) begin
            w_meas  = 1'b1;
            w_cnt_n = PER_W'(1);
        end else if (r_cnt == TMO) begin
            w_tout    = 1'b1;
            w_state_n = ESPERA;
        end else begin
            w_cnt_n = r_cnt + PER_W'(1);
        end
    end

    // State, counter and result registers; results change only on a measurement or a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ESPERA;
            r_cnt     <= '0;
            r_periodo <= '0;
            r_valid   <= 1'b0;
            r_tecla   <= '0;
            r_sil     <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_valid <= w_meas;
            if (w_meas) begin
                r_periodo <= r_cnt;
                r_tecla   <= w_dec;
                r_sil     <= 1'b0;
            end else if (w_tout) begin
                r_periodo <= '0;
                r_tecla   <= '0;
                r_sil     <= 1'b1;
            end
        end
    end

    assign m_if.periodo       = r_periodo;
    assign m_if.periodo_valid = r_valid;
    assign m_if.tecla         = r_tecla;
    assign m_if.silencio      = r_sil;
endmodule

// File: tb/tb_medidor_tono.sv
// tb_medidor_tono: directed checks of the tone meter with time-scaled periods
module tb_medidor_tono;
    localparam int PER_W   = 22;
    localparam int TIMEOUT = 1000;
    localparam int TOL     = 5;
    localparam int P_DO    = 956;
    localparam int P_RE    = 851;
    localparam int P_MI    = 758;
    localparam int P_FA    = 716;
    localparam int P_SOL   = 638;
    localparam int P_LA    = 568;
    localparam int P_SI    = 506;

    int nom [7] = '{P_DO, P_RE, P_MI, P_FA, P_SOL, P_LA, P_SI};
    int offs [4] = '{4, -4, 6, -6};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    medidor_tono_if #(.PER_W(PER_W)) tif ();

    medidor_tono #(
        .PER_W(PER_W), .TIMEOUT(TIMEOUT), .TOL(TOL),
        .P_DO(P_DO), .P_RE(P_RE), .P_MI(P_MI), .P_FA(P_FA),
        .P_SOL(P_SOL), .P_LA(P_LA), .P_SI(P_SI)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .m_if  (tif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising edge on the tone; the pulse for it appears on the fourth sampled edge and lasts one cycle.
    task automatic rise_chk(input string tag, input bit ev, input int ep, input logic [6:0] et);
        tif.tono_in = 1'b1;
        tick();
        tick();
        tick();
        chk({tag, "_early"}, tif.periodo_valid, 0);
        tick();
        chk({tag, "_valid"}, tif.periodo_valid, ev);
        if (ev) begin
            chk({tag, "_periodo"}, tif.periodo, ep);
            chk({tag, "_tecla"}, tif.tecla, et);
            chk({tag, "_silencio"}, tif.silencio, 0);
        end
        tick();
        chk({tag, "_width"}, tif.periodo_valid, 0);
    endtask

    // Completes an interval of n cycles since the last rise (5 cycles already spent in rise_chk).
    task automatic gap(input int n);
        repeat (n / 2 - 5) tick();
        tif.tono_in = 1'b0;
        repeat (n - n / 2) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int n;
        tif.tono_in = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tif.tono_in = ~tif.tono_in;
            tick();
            chk("rst_valid", tif.periodo_valid, 0);
        end
        chk("rst_silencio", tif.silencio, 1);
        chk("rst_tecla", tif.tecla, 0);
        chk("rst_periodo", tif.periodo, 0);
        tif.tono_in = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        rise_chk("la_arm", 0, 0, 7'b0);
        for (int i = 0; i < 4; i++) begin
            gap(P_LA);
            rise_chk("la", 1, P_LA, 7'b0100000);
        end

        tif.tono_in = 1'b0;
        seen = 1'b0;
        repeat (TIMEOUT - 2) begin
            tick();
            seen |= tif.periodo_valid;
        end
        chk("to_early", tif.silencio, 0);
        tick();
        seen |= tif.periodo_valid;
        chk("to_silencio", tif.silencio, 1);
        chk("to_periodo", tif.periodo, 0);
        chk("to_tecla", tif.tecla, 0);
        chk("to_nopulse", seen, 0);

        repeat (20) tick();
        rise_chk("do_arm", 0, 0, 7'b0);
        gap(P_DO);
        rise_chk("do", 1, P_DO, 7'b0000001);

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 4; j++) begin
                n = nom[i] + offs[j];
                gap(n);
                rise_chk("sweep", 1, n, (j < 2) ? 7'(1 << i) : 7'b0);
            end
        end

        gap(TIMEOUT);
        rise_chk("edge_to", 1, TIMEOUT, 7'b0);

        gap(P_MI);
        rise_chk("mi_pre", 1, P_MI, 7'b0000100);
        repeat (200) tick();
        reset = 1'b1;
        tick();
        chk("mrst_periodo", tif.periodo, 0);
        chk("mrst_tecla", tif.tecla, 0);
        chk("mrst_silencio", tif.silencio, 1);
        chk("mrst_valid", tif.periodo_valid, 0);
        tif.tono_in = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        rise_chk("mi_arm", 0, 0, 7'b0);
        gap(P_MI);
        rise_chk("mi", 1, P_MI, 7'b0000100);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
